// File: rtl/e203_icb_arbt_n.sv
// -----------------------------------------------------------------------------
// e203_icb_arbt_n
//
// N-master to 1-slave ICB arbiter with in-order outstanding tracking.
// Merges N command channels onto one downstream ICB port (fixed priority or
// round robin), records the granted master index of every accepted command
// in an ID FIFO and steers each downstream response back to that master.
//
// Handshake semantics (all channels): a transfer happens in a cycle where
// both valid and ready are high at the rising edge of clk. A valid source
// holds valid and payload stable until the transfer; ready may depend
// combinationally on valid.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   i_icb_cmd_*          per-master command channels (master k = slice k)
//   i_icb_rsp_*          per-master response channels
//   o_icb_cmd_*          downstream command channel
//   o_icb_rsp_*          downstream response channel
//   outs_cnt             registered count of outstanding commands
//   busy                 outs_cnt != 0
//   rsp_orphan           sticky: a response arrived with nothing outstanding
// -----------------------------------------------------------------------------
module e203_icb_arbt_n #(
  parameter int N          = 4,
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int OUTS_DEPTH = 4,
  parameter int ARBT_MODE  = 1,
  localparam int IW        = (N < 2) ? 1 : $clog2(N),
  localparam int CW        = $clog2(OUTS_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic [N-1:0]        i_icb_cmd_valid,
  output logic [N-1:0]        i_icb_cmd_ready,
  input  logic [N*AW-1:0]     i_icb_cmd_addr,
  input  logic [N-1:0]        i_icb_cmd_read,
  input  logic [N*DW-1:0]     i_icb_cmd_wdata,
  input  logic [N*DW/8-1:0]   i_icb_cmd_wmask,

  output logic [N-1:0]        i_icb_rsp_valid,
  input  logic [N-1:0]        i_icb_rsp_ready,
  output logic [N-1:0]        i_icb_rsp_err,
  output logic [N*DW-1:0]     i_icb_rsp_rdata,

  output logic                o_icb_cmd_valid,
  input  logic                o_icb_cmd_ready,
  output logic [AW-1:0]       o_icb_cmd_addr,
  output logic                o_icb_cmd_read,
  output logic [DW-1:0]       o_icb_cmd_wdata,
  output logic [DW/8-1:0]     o_icb_cmd_wmask,

  input  logic                o_icb_rsp_valid,
  output logic                o_icb_rsp_ready,
  input  logic                o_icb_rsp_err,
  input  logic [DW-1:0]       o_icb_rsp_rdata,

  output logic [CW-1:0]       outs_cnt,
  output logic                busy,
  output logic                rsp_orphan
);

  localparam int PW  = (OUTS_DEPTH < 2) ? 1 : $clog2(OUTS_DEPTH);
  localparam int CIW = IW + 1;

  logic [IW-1:0] rr_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [IW-1:0] id_fifo [OUTS_DEPTH];

  logic [N-1:0]  grant;
  logic [IW-1:0] grant_idx;
  logic          grant_found;
  logic [CIW-1:0] cand;

  logic          full;
  logic          has_outs;
  logic          cmd_hsk;
  logic          rsp_pop;
  logic [IW-1:0] head;

  // ---------------------------------------------------------------------------
  // Grant: first valid master found scanning from the start point. In round
  // robin mode the scan starts at rr_ptr and wraps; cand is one bit wider than
  // an index so rr_ptr + i never overflows before the wrap subtraction.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    cand        = '0;
    for (int i = 0; i < N; i++) begin
      if (ARBT_MODE != 0) begin
        cand = {1'b0, rr_ptr} + CIW'(i);
        if (cand >= CIW'(N)) cand = cand - CIW'(N);
      end else begin
        cand = CIW'(i);
      end
      if (!grant_found && i_icb_cmd_valid[cand[IW-1:0]]) begin
        grant_found            = 1'b1;
        grant[cand[IW-1:0]]    = 1'b1;
        grant_idx              = cand[IW-1:0];
      end
    end
  end

  // One-hot AND-OR payload mux over the granted slice.
  always_comb begin
    o_icb_cmd_addr  = '0;
    o_icb_cmd_read  = 1'b0;
    o_icb_cmd_wdata = '0;
    o_icb_cmd_wmask = '0;
    for (int k = 0; k < N; k++) begin
      if (grant[k]) begin
        o_icb_cmd_addr  = o_icb_cmd_addr  | i_icb_cmd_addr[k*AW +: AW];
        o_icb_cmd_read  = o_icb_cmd_read  | i_icb_cmd_read[k];
        o_icb_cmd_wdata = o_icb_cmd_wdata | i_icb_cmd_wdata[k*DW +: DW];
        o_icb_cmd_wmask = o_icb_cmd_wmask | i_icb_cmd_wmask[k*(DW/8) +: (DW/8)];
      end
    end
  end

  // Full blocks commands on the registered count only: a pop in the same
  // cycle does not free a slot until the next cycle.
  assign full     = (outs_cnt == CW'(OUTS_DEPTH));
  assign has_outs = (outs_cnt != '0);
  assign busy     = has_outs;
  assign head     = id_fifo[rd_ptr];

  assign o_icb_cmd_valid = rst_n & (|i_icb_cmd_valid) & ~full;
  assign i_icb_cmd_ready = rst_n ? (grant & {N{o_icb_cmd_ready & ~full}}) : '0;
  assign cmd_hsk         = o_icb_cmd_valid & o_icb_cmd_ready;

  // ---------------------------------------------------------------------------
  // Response routing. With nothing outstanding the downstream response is
  // sunk (ready = 1) and no master sees it; that is the orphan case.
  // ---------------------------------------------------------------------------
  always_comb begin
    i_icb_rsp_valid = '0;
    if (rst_n && has_outs) i_icb_rsp_valid[head] = o_icb_rsp_valid;
  end

  assign i_icb_rsp_err   = {N{o_icb_rsp_err}};
  assign i_icb_rsp_rdata = {N{o_icb_rsp_rdata}};
  assign o_icb_rsp_ready = rst_n & (has_outs ? i_icb_rsp_ready[head] : 1'b1);
  assign rsp_pop         = has_outs & o_icb_rsp_valid & o_icb_rsp_ready;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUTS_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // ID FIFO storage carries no reset; entries are only read while counted.
  always_ff @(posedge clk) begin
    if (rst_n && cmd_hsk) id_fifo[wr_ptr] <= grant_idx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outs_cnt   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rr_ptr     <= '0;
      rsp_orphan <= 1'b0;
    end else begin
      if (cmd_hsk) begin
        wr_ptr <= ptr_inc(wr_ptr);
        if (ARBT_MODE != 0)
          rr_ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
      end
      if (rsp_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({cmd_hsk, rsp_pop})
        2'b10:   outs_cnt <= outs_cnt + CW'(1);
        2'b01:   outs_cnt <= outs_cnt - CW'(1);
        default: outs_cnt <= outs_cnt;
      endcase
      if (!has_outs && o_icb_rsp_valid) rsp_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_e203_icb_arbt_n.sv
// -----------------------------------------------------------------------------
// Bench for e203_icb_arbt_n: a round-robin instance driven by hand-written
// sequences with a response scoreboard, and a fixed-priority instance driven
// from a vector table. Both share the command payload and response data.
// -----------------------------------------------------------------------------
module tb_e203_icb_arbt_n;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int W  = 2;

  // ---------------------------------------------------------------- clock/reset
  logic clk;
  logic rst_n;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------- shared
  logic [N*AW-1:0]   cmd_addr;
  logic [N-1:0]      cmd_read;
  logic [N*DW-1:0]   cmd_wdata;
  logic [N*DW/8-1:0] cmd_wmask;
  logic              o_rsp_err;
  logic [DW-1:0]     o_rsp_rdata;

  // ---------------------------------------------------------------- RR DUT
  logic [N-1:0]    cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
  logic [N*DW-1:0] rsp_rdata;
  logic            o_cmd_valid, o_cmd_ready, o_cmd_read;
  logic [AW-1:0]   o_cmd_addr;
  logic [DW-1:0]   o_cmd_wdata;
  logic [DW/8-1:0] o_cmd_wmask;
  logic            o_rsp_valid, o_rsp_ready;
  logic [2:0]      outs_cnt;
  logic            busy, rsp_orphan;

  e203_icb_arbt_n #(.N(N), .AW(AW), .DW(DW), .OUTS_DEPTH(4), .ARBT_MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .i_icb_cmd_valid(cmd_valid), .i_icb_cmd_ready(cmd_ready),
    .i_icb_cmd_addr(cmd_addr), .i_icb_cmd_read(cmd_read),
    .i_icb_cmd_wdata(cmd_wdata), .i_icb_cmd_wmask(cmd_wmask),
    .i_icb_rsp_valid(rsp_valid), .i_icb_rsp_ready(rsp_ready),
    .i_icb_rsp_err(rsp_err), .i_icb_rsp_rdata(rsp_rdata),
    .o_icb_cmd_valid(o_cmd_valid), .o_icb_cmd_ready(o_cmd_ready),
    .o_icb_cmd_addr(o_cmd_addr), .o_icb_cmd_read(o_cmd_read),
    .o_icb_cmd_wdata(o_cmd_wdata), .o_icb_cmd_wmask(o_cmd_wmask),
    .o_icb_rsp_valid(o_rsp_valid), .o_icb_rsp_ready(o_rsp_ready),
    .o_icb_rsp_err(o_rsp_err), .o_icb_rsp_rdata(o_rsp_rdata),
    .outs_cnt(outs_cnt), .busy(busy), .rsp_orphan(rsp_orphan)
  );

  // ---------------------------------------------------------------- FP DUT
  logic [N-1:0]    f_cmd_valid, f_cmd_ready, f_rsp_valid, f_rsp_ready, f_rsp_err;
  logic [N*DW-1:0] f_rsp_rdata;
  logic            f_o_cmd_valid, f_o_cmd_ready, f_o_cmd_read;
  logic [AW-1:0]   f_o_cmd_addr;
  logic [DW-1:0]   f_o_cmd_wdata;
  logic [DW/8-1:0] f_o_cmd_wmask;
  logic            f_o_rsp_valid, f_o_rsp_ready;
  logic [2:0]      f_outs_cnt;
  logic            f_busy, f_rsp_orphan;

  e203_icb_arbt_n #(.N(N), .AW(AW), .DW(DW), .OUTS_DEPTH(4), .ARBT_MODE(0)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .i_icb_cmd_valid(f_cmd_valid), .i_icb_cmd_ready(f_cmd_ready),
    .i_icb_cmd_addr(cmd_addr), .i_icb_cmd_read(cmd_read),
    .i_icb_cmd_wdata(cmd_wdata), .i_icb_cmd_wmask(cmd_wmask),
    .i_icb_rsp_valid(f_rsp_valid), .i_icb_rsp_ready(f_rsp_ready),
    .i_icb_rsp_err(f_rsp_err), .i_icb_rsp_rdata(f_rsp_rdata),
    .o_icb_cmd_valid(f_o_cmd_valid), .o_icb_cmd_ready(f_o_cmd_ready),
    .o_icb_cmd_addr(f_o_cmd_addr), .o_icb_cmd_read(f_o_cmd_read),
    .o_icb_cmd_wdata(f_o_cmd_wdata), .o_icb_cmd_wmask(f_o_cmd_wmask),
    .o_icb_rsp_valid(f_o_rsp_valid), .o_icb_rsp_ready(f_o_rsp_ready),
    .o_icb_rsp_err(o_rsp_err), .o_icb_rsp_rdata(o_rsp_rdata),
    .outs_cnt(f_outs_cnt), .busy(f_busy), .rsp_orphan(f_rsp_orphan)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] rd_tag = 32'hD000_0000;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] addr_of(input int k);
    return 32'h1000_0000 + 32'(k) * 32'h10;
  endfunction

  function automatic logic [31:0] wdata_of(input int k);
    return 32'h5A00_0000 + 32'(k);
  endfunction

  // One cycle on the round-robin DUT. exp_g is the master expected to be
  // granted (-1: no command may go out). Response routing is checked against
  // the head of the expected-ID queue.
  task automatic rr_cycle(input logic [3:0] v, input logic oready, input logic rvalid,
                          input logic rerr, input logic [31:0] rdata,
                          input logic [3:0] rready, input int exp_g);
    int head;
    @(posedge clk); #1;
    cmd_valid   = v;
    o_cmd_ready = oready;
    o_rsp_valid = rvalid;
    o_rsp_err   = rerr;
    o_rsp_rdata = rdata;
    rsp_ready   = rready;
    @(negedge clk);
    if (exp_g >= 0) begin
      check("cmd_valid", o_cmd_valid, 1);
      check("cmd_ready", cmd_ready, oready ? (4'b1 << exp_g) : 4'b0);
      check("cmd_addr", o_cmd_addr, addr_of(exp_g));
      check("cmd_wdata", o_cmd_wdata, wdata_of(exp_g));
      check("cmd_read", o_cmd_read, exp_g[0]);
    end else begin
      check("cmd_valid_blocked", o_cmd_valid, 0);
      check("cmd_ready_blocked", cmd_ready, 0);
    end
    if (exp_q.size() != 0) begin
      head = int'(exp_q[0]);
      check("rsp_valid_route", rsp_valid, rvalid ? (4'b1 << head) : 4'b0);
      check("o_rsp_ready", o_rsp_ready, rready[head]);
      if (rvalid) begin
        check("rsp_rdata", rsp_rdata[head*DW +: DW], rdata);
        check("rsp_err", rsp_err[head], rerr);
      end
      if (rvalid && rready[head]) void'(exp_q.pop_front());
    end else if (rvalid) begin
      check("orphan_rsp_valid", rsp_valid, 0);
      check("orphan_sink", o_rsp_ready, 1);
    end
    if (exp_g >= 0 && oready) exp_q.push_back(W'(exp_g));
  endtask

  // Slave always ready; respond whenever something is expected outstanding.
  task automatic rr_auto(input logic [3:0] v, input int exp_g);
    rd_tag = rd_tag + 32'd1;
    rr_cycle(v, 1'b1, exp_q.size() != 0, 1'b0, rd_tag, 4'hF, exp_g);
  endtask

  // ---------------------------------------------------------------- FP table
  typedef struct {
    logic [3:0] v;
    logic       oready;
    logic       exp_valid;
    logic [3:0] exp_ready;
    int         exp_g;
  } fp_vec_t;

  fp_vec_t fp_tab[8];

  // ---------------------------------------------------------------- watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------- main
  initial begin
    fp_tab[0] = '{4'b0000, 1'b1, 1'b0, 4'b0000, -1};
    fp_tab[1] = '{4'b1010, 1'b1, 1'b1, 4'b0010,  1};
    fp_tab[2] = '{4'b1010, 1'b1, 1'b1, 4'b0010,  1};
    fp_tab[3] = '{4'b1010, 1'b1, 1'b1, 4'b0010,  1};
    fp_tab[4] = '{4'b1000, 1'b1, 1'b1, 4'b1000,  3};
    fp_tab[5] = '{4'b1111, 1'b0, 1'b1, 4'b0000,  0};
    fp_tab[6] = '{4'b1100, 1'b1, 1'b1, 4'b0100,  2};
    fp_tab[7] = '{4'b0001, 1'b1, 1'b1, 4'b0001,  0};

    for (int k = 0; k < N; k++) begin
      cmd_addr[k*AW +: AW]       = addr_of(k);
      cmd_wdata[k*DW +: DW]      = wdata_of(k);
      cmd_read[k]                = k[0];
      cmd_wmask[k*(DW/8) +: DW/8] = 4'(k + 1);
    end
    rst_n = 1'b0;
    cmd_valid = '0; o_cmd_ready = 1'b0; o_rsp_valid = 1'b0; rsp_ready = '0;
    o_rsp_err = 1'b0; o_rsp_rdata = '0;
    f_cmd_valid = '0; f_o_cmd_ready = 1'b0; f_o_rsp_valid = 1'b0; f_rsp_ready = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outs_cnt", outs_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_orphan", rsp_orphan, 0);
    check("rst_o_cmd_valid", o_cmd_valid, 0);
    check("rst_o_rsp_ready", o_rsp_ready, 0);
    rst_n = 1'b1;

    // Fixed priority table; slave answers every outstanding command at once.
    f_o_rsp_valid = 1'b1;
    f_rsp_ready   = 4'hF;
    for (int r = 0; r < 8; r++) begin
      @(posedge clk); #1;
      f_cmd_valid   = fp_tab[r].v;
      f_o_cmd_ready = fp_tab[r].oready;
      @(negedge clk);
      check($sformatf("fp_valid[%0d]", r), f_o_cmd_valid, fp_tab[r].exp_valid);
      check($sformatf("fp_ready[%0d]", r), f_cmd_ready, fp_tab[r].exp_ready);
      if (fp_tab[r].exp_valid) begin
        check($sformatf("fp_addr[%0d]", r), f_o_cmd_addr, addr_of(fp_tab[r].exp_g));
        check($sformatf("fp_wdata[%0d]", r), f_o_cmd_wdata, wdata_of(fp_tab[r].exp_g));
        check($sformatf("fp_wmask[%0d]", r), f_o_cmd_wmask, 4'(fp_tab[r].exp_g + 1));
      end
    end
    @(posedge clk); #1;
    f_cmd_valid = '0; f_o_rsp_valid = 1'b0;

    // Round robin between masters 1 and 3
    rr_auto(4'b1010, 1);
    rr_auto(4'b1010, 3);
    rr_auto(4'b1010, 1);
    rr_auto(4'b1010, 3);

    // All four masters valid, responses one cycle later
    for (int c = 0; c < 8; c++) begin
      rr_auto(4'b1111, c % 4);
      check("outs_le_1", outs_cnt <= 3'd1, 1);
    end
    rr_auto(4'b0000, -1);

    // Fill to OUTS_DEPTH with responses withheld
    for (int c = 0; c < 4; c++) rr_cycle(4'b0001, 1'b1, 1'b0, 1'b0, 32'h0, 4'hF, 0);
    rr_cycle(4'b0001, 1'b1, 1'b0, 1'b0, 32'h0, 4'hF, -1);
    check("full_outs_cnt", outs_cnt, 4);
    check("full_busy", busy, 1);
    // Release one response: no same-cycle bypass, accepted the cycle after
    rr_cycle(4'b0001, 1'b1, 1'b1, 1'b0, 32'h1111, 4'hF, -1);
    check("pop_cycle_cnt", outs_cnt, 4);
    rr_cycle(4'b0001, 1'b1, 1'b0, 1'b0, 32'h0, 4'hF, 0);
    check("refill_cnt", outs_cnt, 3);
    for (int c = 0; c < 4; c++) rr_cycle(4'b0000, 1'b1, 1'b1, 1'b0, 32'h2000 + 32'(c), 4'hF, -1);
    rr_cycle(4'b0000, 1'b1, 1'b0, 1'b0, 32'h0, 4'hF, -1);
    check("drained_cnt", outs_cnt, 0);
    check("drained_busy", busy, 0);

    // Interleaved issue 2,0,2 (rr_ptr at 1 here)
    rr_cycle(4'b0100, 1'b1, 1'b0, 1'b0, 32'h0, 4'hF, 2);
    rr_cycle(4'b0001, 1'b1, 1'b0, 1'b0, 32'h0, 4'hF, 0);
    rr_cycle(4'b0100, 1'b1, 1'b0, 1'b0, 32'h0, 4'hF, 2);
    rr_cycle(4'b0000, 1'b1, 1'b1, 1'b0, 32'hA, 4'hF, -1);
    rr_cycle(4'b0000, 1'b1, 1'b1, 1'b1, 32'hB, 4'hF, -1);
    rr_cycle(4'b0000, 1'b1, 1'b1, 1'b0, 32'hC, 4'hF, -1);

    // Head master 1 withholds rsp ready for three cycles
    rr_cycle(4'b0010, 1'b1, 1'b0, 1'b0, 32'h0, 4'hF, 1);
    for (int c = 0; c < 3; c++) begin
      rr_cycle(4'b0000, 1'b1, 1'b1, 1'b0, 32'h3000, 4'b1101, -1);
      check("hold_outs_cnt", outs_cnt, 1);
    end
    rr_cycle(4'b0000, 1'b1, 1'b1, 1'b0, 32'h3001, 4'hF, -1);
    rr_cycle(4'b0000, 1'b1, 1'b0, 1'b0, 32'h0, 4'hF, -1);
    check("hold_drained", outs_cnt, 0);

    // Orphan response on an idle bus
    check("pre_orphan", rsp_orphan, 0);
    rr_cycle(4'b0000, 1'b1, 1'b1, 1'b0, 32'hBAD, 4'hF, -1);
    rr_cycle(4'b0000, 1'b1, 1'b0, 1'b0, 32'h0, 4'hF, -1);
    check("orphan_set", rsp_orphan, 1);
    rr_cycle(4'b0000, 1'b1, 1'b0, 1'b0, 32'h0, 4'hF, -1);
    check("orphan_sticky", rsp_orphan, 1);

    // Reset with two commands outstanding
    rr_cycle(4'b0001, 1'b1, 1'b0, 1'b0, 32'h0, 4'hF, 0);
    rr_cycle(4'b0001, 1'b1, 1'b0, 1'b0, 32'h0, 4'hF, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    cmd_valid = 4'hF; o_cmd_ready = 1'b1; o_rsp_valid = 1'b1; rsp_ready = 4'hF;
    @(negedge clk);
    check("rst_force_cmd_valid", o_cmd_valid, 0);
    check("rst_force_cmd_ready", cmd_ready, 0);
    check("rst_force_rsp_valid", rsp_valid, 0);
    check("rst_force_rsp_ready", o_rsp_ready, 0);
    @(negedge clk);
    check("mid_rst_outs_cnt", outs_cnt, 0);
    check("mid_rst_orphan", rsp_orphan, 0);
    check("mid_rst_busy", busy, 0);
    exp_q.delete();
    cmd_valid = '0; o_rsp_valid = 1'b0;
    rst_n = 1'b1;
    // Late response to a pre-reset command is an orphan; rr_ptr back at 0
    rr_cycle(4'b1111, 1'b1, 1'b1, 1'b0, 32'h4444, 4'hF, 0);
    rr_cycle(4'b0000, 1'b1, 1'b1, 1'b0, 32'h5555, 4'hF, -1);
    check("post_rst_orphan", rsp_orphan, 1);
    rr_cycle(4'b0000, 1'b1, 1'b0, 1'b0, 32'h0, 4'hF, -1);
    check("final_outs_cnt", outs_cnt, 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
